// File: rtl/lc3_uart_loader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : lc3_loader_pkg
// Purpose  : Shared types and baud-rate helpers for the LC-3 UART loader.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package lc3_loader_pkg;

  // Loader frame-parsing states; IDLE keeps its encoding but is never entered.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CSUM    = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } load_state_t;

  // Serial receiver states.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Clock cycles per UART bit (integer division).
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Clock cycles from start edge to the middle of the start bit.
  function automatic int calc_half_div(input int clk_hz, input int baud);
    return calc_div(clk_hz, baud) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_uart_loader_uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : uart_rx
// Purpose  : 8N1 serial receiver with 2-flop synchronizer, start-glitch
//            rejection and stop-bit framing-error detection.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module uart_rx #(
  parameter int DIV      = 868,
  parameter int HALF_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       ferr
);
  import lc3_loader_pkg::*;

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);

  logic            sync_1;
  logic            sync_2;
  logic            sync_3;
  logic            line;
  logic            fall;
  rx_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  assign line = sync_2;
  assign fall = sync_3 & ~sync_2;

  // Bring the asynchronous line into the clock domain; keep one extra flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      sync_3 <= 1'b1;
    end else begin
      sync_1 <= rx;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

  // Bit-timing state machine: validate start mid-bit, shift data LSB first, check stop mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      ferr     <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (fall) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A line that is high again mid start bit was only a glitch.
            state   <= line ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shift <= {line, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (line) begin
              rx_valid <= 1'b1;
              rx_byte  <= shift;
            end else begin
              ferr <= 1'b1;
            end
            // Return to idle at the stop sample; a start edge seen in this very cycle is kept.
            state <= fall ? RX_START : RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/lc3_uart_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : lc3_uart_loader
// Purpose  : Receives a length-prefixed, XOR-checksummed program image over
//            UART, writes it to memory from address 0 and releases the core.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module lc3_uart_loader #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 12
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              uart_rx,
  output logic [ADDR_W-1:0] mem_a,
  output logic [15:0]       mem_d,
  output logic              mem_we,
  output logic              run,
  output logic              err,
  output logic [15:0]       word_cnt
);
  import lc3_loader_pkg::*;

  localparam int DIV      = calc_div(CLK_HZ, BAUD);
  localparam int HALF_DIV = calc_half_div(CLK_HZ, BAUD);
  // Largest legal image, held one bit wider than the length field so 2^16 fits.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              ferr;

  load_state_t       state;
  logic [15:0]       len;
  logic [7:0]        hi_byte;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       next_len;
  logic [15:0]       next_cnt;

  assign next_len = {len[15:8], rx_byte};
  assign next_cnt = word_cnt + 16'd1;

  uart_rx #(
    .DIV      (DIV),
    .HALF_DIV (HALF_DIV)
  ) u_rx (
    .clk      (clk_100mhz),
    .rst      (rst),
    .rx       (uart_rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .ferr     (ferr)
  );

  // Frame parser: consumes one received byte per step and drives the write port and status flags.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state    <= ST_LEN_HI;
      len      <= '0;
      hi_byte  <= '0;
      csum     <= '0;
      addr     <= '0;
      mem_a    <= '0;
      mem_d    <= '0;
      mem_we   <= 1'b0;
      run      <= 1'b0;
      err      <= 1'b0;
      word_cnt <= '0;
    end else begin
      mem_we <= 1'b0;
      if (ferr && (state != ST_DONE) && (state != ST_ERR)) begin
        state <= ST_ERR;
        err   <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          ST_LEN_HI: begin
            len[15:8] <= rx_byte;
            csum      <= csum ^ rx_byte;
            state     <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            len  <= next_len;
            csum <= csum ^ rx_byte;
            if (next_len == 16'd0) begin
              state <= ST_CSUM;
            end else if ({1'b0, next_len} > MAX_WORDS) begin
              state <= ST_ERR;
              err   <= 1'b1;
            end else begin
              state <= ST_DATA_HI;
            end
          end
          ST_DATA_HI: begin
            hi_byte <= rx_byte;
            csum    <= csum ^ rx_byte;
            state   <= ST_DATA_LO;
          end
          ST_DATA_LO: begin
            mem_a    <= addr;
            mem_d    <= {hi_byte, rx_byte};
            mem_we   <= 1'b1;
            addr     <= addr + 1'b1;
            word_cnt <= next_cnt;
            csum     <= csum ^ rx_byte;
            state    <= (next_cnt == len) ? ST_CSUM : ST_DATA_HI;
          end
          ST_CSUM: begin
            if (rx_byte == csum) begin
              state <= ST_DONE;
              run   <= 1'b1;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
          // DONE and ERR hold until reset; IDLE is reserved and simply waits.
          default: state <= state;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lc3_uart_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_lc3_uart_loader
// Purpose  : Scoreboard bench for the UART program loader. Frames are parsed
//            by a frame-level model into expected write/run/err events; a
//            monitor pops and compares them as the loader produces them.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_lc3_uart_loader;

  // Fast bit clock keeps the run short: 16 cycles per bit.
  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int ADDR_W = 12;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int MAXN   = 1 << ADDR_W;

  localparam int EV_WR  = 0;
  localparam int EV_RUN = 1;
  localparam int EV_ERR = 2;

  typedef struct {
    int kind;
    int a;
    int d;
    int cnt;
  } ev_t;

  logic              clk_100mhz = 1'b0;
  logic              rst        = 1'b1;
  logic              uart_rx    = 1'b1;
  logic [ADDR_W-1:0] mem_a;
  logic [15:0]       mem_d;
  logic              mem_we;
  logic              run;
  logic              err;
  logic [15:0]       word_cnt;

  ev_t        exp_q[$];
  logic [7:0] frame_q[$];
  int         checks = 0;
  int         errors = 0;

  lc3_uart_loader #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .mem_a      (mem_a),
    .mem_d      (mem_d),
    .mem_we     (mem_we),
    .run        (run),
    .err        (err),
    .word_cnt   (word_cnt)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_100mhz);
  endtask

  task automatic push_ev(input int kind, input int a, input int d, input int cnt);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.d    = d;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  // Reference: interpret the byte stream as a frame and list what the loader must do.
  task automatic model_frame();
    int         n;
    int         idx;
    logic [7:0] x;
    if (frame_q.size() < 2) return;
    n = {frame_q[0], frame_q[1]};
    x = frame_q[0] ^ frame_q[1];
    if (n > MAXN) begin
      push_ev(EV_ERR, 0, 0, 0);
      return;
    end
    for (int w = 0; w < n; w++) begin
      idx = 2 + 2 * w;
      if (idx + 1 >= frame_q.size()) return;
      push_ev(EV_WR, w % MAXN, {frame_q[idx], frame_q[idx + 1]}, w + 1);
      x = x ^ frame_q[idx] ^ frame_q[idx + 1];
    end
    idx = 2 + 2 * n;
    if (idx >= frame_q.size()) return;
    push_ev((frame_q[idx] == x) ? EV_RUN : EV_ERR, 0, 0, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(DIV);
    end
    uart_rx = stop;
    tick(DIV);
    uart_rx = 1'b1;
    tick($urandom_range(0, 3));
  endtask

  // Bounded wait for all expected events, then a short quiet period for stray ones.
  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4 * DIV) begin
      tick(1);
      t++;
    end
    chk("pending_events", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick(DIV);
  endtask

  task automatic send_frame();
    model_frame();
    foreach (frame_q[i]) send_byte(frame_q[i], 1'b1);
    drain();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    chk("rst_mem_a", 32'(mem_a), 32'd0);
    chk("rst_mem_d", 32'(mem_d), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_run", 32'(run), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    tick(2);
  endtask

  task automatic set_nominal(input logic [7:0] cs);
    frame_q.delete();
    frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    frame_q.push_back(cs);
  endtask

  task automatic chk_status(input string nm, input logic exp_run, input logic exp_err, input int exp_cnt);
    chk({nm, "_run"}, 32'(run), 32'(exp_run));
    chk({nm, "_err"}, 32'(err), 32'(exp_err));
    chk({nm, "_word_cnt"}, 32'(word_cnt), exp_cnt);
  endtask

  // Monitor: every write strobe or run/err rising edge consumes one expected event.
  initial begin : monitor
    logic run_prev;
    logic err_prev;
    ev_t  e;
    run_prev = 1'b0;
    err_prev = 1'b0;
    forever begin
      @(negedge clk_100mhz);
      if (rst) begin
        run_prev = 1'b0;
        err_prev = 1'b0;
      end else begin
        if (mem_we) begin
          chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("write_kind", EV_WR, e.kind);
            chk("mem_a", 32'(mem_a), e.a);
            chk("mem_d", 32'(mem_d), e.d);
            chk("word_cnt_at_write", 32'(word_cnt), e.cnt);
          end
        end
        if (run && !run_prev) begin
          chk("run_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("run_kind", EV_RUN, e.kind);
          end
        end
        if (err && !err_prev) begin
          chk("err_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("err_kind", EV_ERR, e.kind);
          end
        end
        run_prev = run;
        err_prev = err;
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    int         n;
    logic [7:0] x;
    do_reset();

    // Nominal two-word image.
    set_nominal(8'h42);
    send_frame();
    chk_status("nominal", 1'b1, 1'b0, 2);
    chk("nominal_mem_a_held", 32'(mem_a), 32'd1);
    chk("nominal_mem_d_held", 32'(mem_d), 32'hABCD);

    // Wrong checksum followed by trailing bytes that must be ignored.
    do_reset();
    set_nominal(8'h43);
    frame_q.push_back(8'hFF);
    frame_q.push_back(8'h00);
    frame_q.push_back(8'h11);
    frame_q.push_back(8'h22);
    send_frame();
    chk_status("badcsum", 1'b0, 1'b1, 2);

    // Empty image.
    do_reset();
    frame_q = '{8'h00, 8'h00, 8'h00};
    send_frame();
    chk_status("empty", 1'b1, 1'b0, 0);

    // One word over the limit.
    do_reset();
    frame_q = '{8'h10, 8'h01};
    send_frame();
    chk_status("oversize", 1'b0, 1'b1, 0);

    // Exactly the limit is a legal length.
    do_reset();
    frame_q = '{8'h10, 8'h00};
    send_frame();
    chk_status("maxlen", 1'b0, 1'b0, 0);

    // Low pulse shorter than half a bit, then a normal frame.
    do_reset();
    uart_rx = 1'b0;
    tick(DIV / 4);
    uart_rx = 1'b1;
    tick(3 * DIV);
    set_nominal(8'h42);
    send_frame();
    chk_status("glitch", 1'b1, 1'b0, 2);

    // Stop bit low on the first byte.
    do_reset();
    push_ev(EV_ERR, 0, 0, 0);
    send_byte(8'h00, 1'b0);
    drain();
    chk_status("ferr", 1'b0, 1'b1, 0);

    // Reset after the hi byte of word 1, then a full reload.
    do_reset();
    frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_frame();
    chk_status("partial", 1'b0, 1'b0, 1);
    do_reset();
    set_nominal(8'h42);
    send_frame();
    chk_status("reload", 1'b1, 1'b0, 2);

    // Random frames: mostly small legal images, some bad checksums, some oversize.
    for (int k = 0; k < 6; k++) begin
      do_reset();
      frame_q.delete();
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(MAXN + 1, 65535);
        frame_q.push_back(n[15:8]);
        frame_q.push_back(n[7:0]);
        frame_q.push_back(8'($urandom));
      end else begin
        n = $urandom_range(0, 5);
        frame_q.push_back(n[15:8]);
        frame_q.push_back(n[7:0]);
        for (int w = 0; w < 2 * n; w++) frame_q.push_back(8'($urandom));
        x = 8'h00;
        foreach (frame_q[i]) x = x ^ frame_q[i];
        if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
        frame_q.push_back(x);
      end
      send_frame();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
